// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, abort codes and
// the keyboard command bytes the controller issues.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_RTS       = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'b00,
    ERR_START = 2'b01,
    ERR_XFER  = 2'b10,
    ERR_NOACK = 2'b11
  } err_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  // One timer serves the phase lengths and both timeouts.
  localparam int TMR_W = 21;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the PS/2 clock and data lines plus a one-cycle
// falling-edge strobe on the synchronised clock (3 cycles after the line).
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [1:0] clk_sync;
  logic [1:0] data_sync;
  logic       clk_prev;

  // An idle PS/2 bus is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], clk_in};
      data_sync <= {data_sync[0], data_in};
      clk_prev  <= clk_sync[1];
    end
  end

  assign clk_s    = clk_sync[1];
  assign data_s   = data_sync[1];
  assign clk_fall = clk_prev & ~clk_sync[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then shift one
// byte plus odd parity out on device clock edges and check the device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int RTS_CYCLES     = 100,
  parameter int START_TIMEOUT  = 1500000,
  parameter int XFER_TIMEOUT   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output state_e     state_dbg
);

  // tx_valid/tx_ready: a byte is taken on any cycle where both are high;
  // tx_ready is high only in IDLE, so tx_valid is ignored while busy.

  localparam logic [TMR_W-1:0] INHIBIT_LAST = TMR_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMR_W-1:0] RTS_LAST     = TMR_W'(RTS_CYCLES - 1);
  localparam logic [TMR_W-1:0] START_LAST   = TMR_W'(START_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] XFER_LAST    = TMR_W'(XFER_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE      = TMR_W'(1);

  logic clk_s, data_s, clk_fall;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .clk_in   (ps2_clk_in),
    .data_in  (ps2_data_in),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .clk_fall (clk_fall)
  );

  state_e           state_q, state_n;
  logic [TMR_W-1:0] tmr_q, tmr_n;
  logic [3:0]       bit_q, bit_n;
  logic [8:0]       sh_q, sh_n;
  logic             clk_oe_q, clk_oe_n;
  logic             data_oe_q, data_oe_n;
  logic             done_q, done_n;
  logic             err_q, err_n;
  err_e             code_q, code_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             abort;
  err_e             abort_code;
  logic             xfer_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tmr_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= ERR_NONE;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_n;
      tmr_q     <= tmr_n;
      bit_q     <= bit_n;
      sh_q      <= sh_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      done_q    <= done_n;
      err_q     <= err_n;
      code_q    <= code_n;
      ready_q   <= ready_n;
      busy_q    <= busy_n;
    end
  end

  assign xfer_expired = (tmr_q >= XFER_LAST);

  always_comb begin
    state_n    = state_q;
    tmr_n      = tmr_q;
    bit_n      = bit_q;
    sh_n       = sh_q;
    clk_oe_n   = clk_oe_q;
    data_oe_n  = data_oe_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    code_n     = code_q;
    abort      = 1'b0;
    abort_code = ERR_NONE;

    unique case (state_q)
      ST_IDLE: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        if (tx_valid && ready_q) begin
          sh_n     = {odd_parity(tx_data), tx_data};
          code_n   = ERR_NONE;
          clk_oe_n = 1'b1;
          tmr_n    = '0;
          bit_n    = '0;
          state_n  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (tmr_q == INHIBIT_LAST) begin
          data_oe_n = 1'b1;
          tmr_n     = '0;
          state_n   = ST_RTS;
        end else begin
          tmr_n = tmr_q + TMR_ONE;
        end
      end

      ST_RTS: begin
        if (tmr_q == RTS_LAST) begin
          clk_oe_n = 1'b0;
          tmr_n    = '0;
          state_n  = ST_SEND;
        end else begin
          tmr_n = tmr_q + TMR_ONE;
        end
      end

      ST_SEND: begin
        // Before the first edge the timer measures the start timeout; the
        // first edge restarts it for the whole-transfer timeout.
        if (bit_q != 4'd0 && xfer_expired) begin
          abort      = 1'b1;
          abort_code = ERR_XFER;
        end else if (clk_fall) begin
          bit_n = bit_q + 4'd1;
          tmr_n = (bit_q == 4'd0) ? '0 : tmr_q + TMR_ONE;
          if (bit_q == 4'd9) begin
            data_oe_n = 1'b0;
            state_n   = ST_ACK;
          end else begin
            data_oe_n = ~sh_q[bit_q];
          end
        end else if (bit_q == 4'd0 && tmr_q >= START_LAST) begin
          abort      = 1'b1;
          abort_code = ERR_START;
        end else begin
          tmr_n = tmr_q + TMR_ONE;
        end
      end

      ST_ACK: begin
        if (xfer_expired) begin
          abort      = 1'b1;
          abort_code = ERR_XFER;
        end else begin
          tmr_n = tmr_q + TMR_ONE;
          if (clk_fall) begin
            if (!data_s) begin
              state_n = ST_WAIT_IDLE;
            end else begin
              abort      = 1'b1;
              abort_code = ERR_NOACK;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (xfer_expired) begin
          abort      = 1'b1;
          abort_code = ERR_XFER;
        end else begin
          tmr_n = tmr_q + TMR_ONE;
          if (clk_s && data_s) begin
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
      end

      default: begin
        clk_oe_n  = 1'b0;
        data_oe_n = 1'b0;
        state_n   = ST_IDLE;
      end
    endcase

    if (abort) begin
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      err_n     = 1'b1;
      code_n    = abort_code;
      state_n   = ST_IDLE;
    end
  end

  assign ready_n = (state_n == ST_IDLE);
  assign busy_n  = (state_n != ST_IDLE);

  assign tx_ready    = ready_q;
  assign busy        = busy_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = code_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: directed sends against a PS/2 device model, with a
// result/frame scoreboard checked by an independent monitor.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, err;
  logic [1:0] err_code;
  state_e     state_dbg;
  logic       ps2_clk_in, ps2_data_in;

  logic bfm_clk_low = 1'b0;
  logic bfm_data_low = 1'b0;
  logic bfm_abort = 1'b0;
  int   bfm_edge = 0;

  int n_vec = 0;
  int n_miss = 0;

  // Expected results {err, done, err_code} and frames {stop, parity, data, start}.
  logic [3:0]  exp_q[$];
  logic [10:0] frame_q[$];
  logic [10:0] got_q[$];
  logic [3:0]  mon_e;
  logic [10:0] mon_f;
  logic [10:0] mon_g;

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = ~(ps2_clk_oe | bfm_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | bfm_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .RTS_CYCLES     (4),
    .START_TIMEOUT  (500),
    .XFER_TIMEOUT   (2000)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] frame_of(input logic [7:0] d, input logic p);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Monitor: pops expectations whenever the DUT reports a result or the
  // device model completes a frame.
  always @(negedge clk) begin
    if (done || err) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {28'd0, err, done, err_code}, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {28'd0, err, done, err_code}, {28'd0, mon_e});
      end
    end
    if (got_q.size() != 0) begin
      mon_g = got_q.pop_front();
      if (frame_q.size() == 0) begin
        check("unexpected_frame", {21'd0, mon_g}, 32'd0);
      end else begin
        mon_f = frame_q.pop_front();
        check("frame", {21'd0, mon_g}, {21'd0, mon_f});
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int g;
    g = 0;
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("send_accept", {31'd0, g < 5000}, 32'd1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device model: waits for request-to-send, clocks out edges at a 40-cycle
  // period sampling data at the end of each low phase, then ACKs (or not).
  task automatic device(input int edges, input logic ack);
    int g;
    logic [10:0] f;
    g = 0;
    f = '0;
    while (!(ps2_clk_in && !ps2_data_in) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("bfm_request", {31'd0, g < 3000}, 32'd1);
    if (g >= 3000) return;
    bfm_edge = 0;
    repeat (10) @(negedge clk);
    f[0] = ps2_data_in;
    for (int k = 1; k <= edges && !bfm_abort; k++) begin
      bfm_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      f[k] = ps2_data_in;
      bfm_edge = k;
      bfm_clk_low = 1'b0;
      repeat (HALF) @(negedge clk);
    end
    if (edges == 10 && !bfm_abort) begin
      if (ack) bfm_data_low = 1'b1;
      repeat (10) @(negedge clk);
      bfm_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      bfm_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      bfm_data_low = 1'b0;
      repeat (HALF) @(negedge clk);
      got_q.push_back(f);
    end
    bfm_clk_low  = 1'b0;
    bfm_data_low = 1'b0;
  endtask

  task automatic measure_req();
    int g, c1, c2;
    g = 0; c1 = 0; c2 = 0;
    @(negedge clk);
    while (!ps2_clk_oe && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (ps2_clk_oe && !ps2_data_oe && c1 < 1000) begin
      c1++;
      @(negedge clk);
    end
    while (ps2_clk_oe && ps2_data_oe && c2 < 1000) begin
      c2++;
      @(negedge clk);
    end
    check("inhibit_len", c1, 20);
    check("rts_len", c2, 4);
  endtask

  task automatic measure_start_timeout();
    int g, c;
    g = 0; c = 0;
    @(negedge clk);
    while (!ps2_clk_oe && g < 100) begin
      @(negedge clk);
      g++;
    end
    while (ps2_clk_oe && g < 1000) begin
      @(negedge clk);
      g++;
    end
    while (!err && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check("start_timeout_cycles", c, 500);
    check("start_to_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("start_to_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("start_to_ready", {31'd0, tx_ready}, 32'd1);
    check("start_to_code", {30'd0, err_code}, 32'd1);
  endtask

  task automatic wait_quiet(input string name);
    int g;
    g = 0;
    @(negedge clk);
    while (!(tx_ready && exp_q.size() == 0 && got_q.size() == 0) && g < 6000) begin
      @(negedge clk);
      g++;
    end
    check(name, {31'd0, g < 6000}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
    check("rst_data_oe", {31'd0, ps2_data_oe}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    check("rst_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // 0xED: data 1,0,1,1,0,1,1,1 LSB first, parity 1.
    exp_q.push_back(4'b0100);
    frame_q.push_back(frame_of(8'hED, 1'b1));
    fork
      send(8'hED);
      device(10, 1'b1);
      measure_req();
    join
    wait_quiet("t1_idle");
    check("t1_code", {30'd0, err_code}, 32'd0);

    // 0xF4: data 0,0,1,0,1,1,1,1, parity 0.
    exp_q.push_back(4'b0100);
    frame_q.push_back(frame_of(8'hF4, 1'b0));
    fork
      send(8'hF4);
      device(10, 1'b1);
    join
    wait_quiet("t2_idle");

    // Silent device: start timeout.
    exp_q.push_back({2'b10, 2'b01});
    fork
      send(8'hF4);
      measure_start_timeout();
    join
    wait_quiet("t3_idle");

    // Device stops after 5 edges: transfer timeout.
    exp_q.push_back({2'b10, 2'b10});
    fork
      send(8'hED);
      device(5, 1'b1);
    join
    wait_quiet("t4a_idle");
    check("t4a_code", {30'd0, err_code}, 32'd2);

    // Device withholds ACK.
    exp_q.push_back({2'b10, 2'b11});
    frame_q.push_back(frame_of(8'hED, 1'b1));
    fork
      send(8'hED);
      device(10, 1'b0);
    join
    wait_quiet("t4b_idle");
    check("t4b_code", {30'd0, err_code}, 32'd3);

    // Reset during bit 4 of 0xF4 (bit 3 is 0, so DATA is pulled low then).
    bfm_edge = 0;
    fork
      begin
        send(8'hF4);
        check("code_clear_on_accept", {30'd0, err_code}, 32'd0);
      end
      device(10, 1'b1);
      begin
        g = 0;
        while (bfm_edge != 4 && g < 3000) begin
          @(negedge clk);
          g++;
        end
        check("t5_reach_bit4", {31'd0, g < 3000}, 32'd1);
        @(negedge clk);
        check("t5_pre_data_oe", {31'd0, ps2_data_oe}, 32'd1);
        #2;
        rst = 1'b0;
        bfm_abort = 1'b1;
        #1;
        check("t5_async_clk_oe", {31'd0, ps2_clk_oe}, 32'd0);
        check("t5_async_data_oe", {31'd0, ps2_data_oe}, 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    check("t5_rst_ready", {31'd0, tx_ready}, 32'd1);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b1;
    bfm_abort = 1'b0;
    repeat (5) @(negedge clk);

    exp_q.push_back(4'b0100);
    frame_q.push_back(frame_of(8'hFF, 1'b1));
    fork
      send(8'hFF);
      device(10, 1'b1);
    join
    wait_quiet("t5_idle");

    // tx_valid held high: 0xF4 then 0xED back-to-back.
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b0100);
    frame_q.push_back(frame_of(8'hF4, 1'b0));
    frame_q.push_back(frame_of(8'hED, 1'b1));
    fork
      begin
        @(negedge clk);
        tx_data  = 8'hF4;
        tx_valid = 1'b1;
        g = 0;
        while (!tx_ready && g < 100) begin
          @(negedge clk);
          g++;
        end
        @(negedge clk);
        tx_data = 8'hED;
        g = 0;
        while (!done && g < 3000) begin
          @(negedge clk);
          g++;
        end
        check("t6_first_done", {31'd0, done}, 32'd1);
        check("t6_ready_at_done", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        check("t6_b2b_busy", {31'd0, busy}, 32'd1);
        check("t6_b2b_state", {29'd0, state_dbg}, {29'd0, ST_INHIBIT});
        tx_valid = 1'b0;
      end
      begin
        device(10, 1'b1);
        device(10, 1'b1);
      end
    join
    wait_quiet("t6_idle");

    check("exp_q_drained", exp_q.size(), 0);
    check("frame_q_drained", frame_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
